// File: rtl/nukv_fifo_rr_arbiter.sv
// nukv_fifo_rr_arbiter: round-robin merge of NUM_PORTS AXI-stream requesters
// into one registered output stream. A grant lasts a whole packet, or a whole
// burst when PACKET_MODE=0. Downstream almost-full only blocks new grants.
module nukv_fifo_rr_arbiter #(
  parameter int unsigned NUM_PORTS   = 4,
  parameter int unsigned DATA_SIZE   = 64,
  parameter int unsigned PACKET_MODE = 1,
  parameter int unsigned MAX_BURST   = 16,
  parameter int unsigned ID_BITS     = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_PORTS*DATA_SIZE-1:0] s_axis_tdata,
  input  logic [NUM_PORTS-1:0]           s_axis_tvalid,
  input  logic [NUM_PORTS-1:0]           s_axis_tlast,
  output logic [NUM_PORTS-1:0]           s_axis_tready,
  output logic [DATA_SIZE-1:0]           m_axis_tdata,
  output logic                           m_axis_tvalid,
  output logic                           m_axis_tlast,
  output logic [ID_BITS-1:0]             m_axis_tid,
  input  logic                           m_axis_tready,
  input  logic                           m_axis_talmostfull
);

  localparam int unsigned GW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int unsigned CW = 8;
  localparam logic [GW-1:0] LAST_RST  = GW'(NUM_PORTS - 1);
  localparam logic [CW-1:0] BURST_END = CW'(MAX_BURST - 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [GW-1:0]          r_grant;
  logic [GW-1:0]          w_grant_nxt;
  logic [GW-1:0]          r_last_port;
  logic [GW-1:0]          w_last_nxt;
  logic [CW-1:0]          r_beat_cnt;
  logic [CW-1:0]          w_beat_cnt_nxt;

  logic [2*NUM_PORTS-1:0] w_dbl;
  logic [NUM_PORTS-1:0]   w_rot;
  int unsigned            w_off;
  logic                   w_sel_vld;
  logic [GW-1:0]          w_sel;

  logic [DATA_SIZE-1:0]   w_sdata [NUM_PORTS];
  logic [NUM_PORTS-1:0]   w_ready;
  logic                   w_out_free;
  logic                   w_accept;
  logic                   w_burst_end;
  logic                   w_release;

  logic [DATA_SIZE-1:0]   r_m_tdata;
  logic                   r_m_tvalid;
  logic                   r_m_tlast;
  logic [ID_BITS-1:0]     r_m_tid;

  // Split the flat input data bus into per-port lanes
  for (genvar gp = 0; gp < NUM_PORTS; gp++) begin : g_unpack
    assign w_sdata[gp] = s_axis_tdata[gp*DATA_SIZE +: DATA_SIZE];
  end

  // Rotate valids so bit 0 is the port right after last_port, then take the lowest set bit
  always_comb begin
    w_dbl     = {s_axis_tvalid, s_axis_tvalid};
    w_rot     = NUM_PORTS'(w_dbl >> (32'(r_last_port) + 32'd1));
    w_off     = 0;
    w_sel_vld = |w_rot;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (w_rot[i]) begin
        w_off = i;
      end
    end
    w_sel = GW'((32'(r_last_port) + 32'd1 + w_off) % NUM_PORTS);
  end

  // Handshake terms for the granted port
  assign w_out_free  = ~r_m_tvalid | m_axis_tready;
  assign w_accept    = (r_state == ST_XFER) & s_axis_tvalid[r_grant] & w_out_free;
  assign w_burst_end = (PACKET_MODE == 0) && (r_beat_cnt == BURST_END);
  assign w_release   = s_axis_tlast[r_grant] | w_burst_end;

  // Only the granted port sees ready, and only while in XFER
  always_comb begin
    w_ready = '0;
    if (r_state == ST_XFER) begin
      w_ready[r_grant] = w_out_free;
    end
  end

  // Next-state logic: arbitrate in IDLE, count beats and release in XFER
  always_comb begin
    w_state_nxt    = r_state;
    w_grant_nxt    = r_grant;
    w_last_nxt     = r_last_port;
    w_beat_cnt_nxt = r_beat_cnt;
    case (r_state)
      ST_IDLE: begin
        if (!m_axis_talmostfull && w_sel_vld) begin
          w_state_nxt = ST_XFER;
          w_grant_nxt = w_sel;
          w_last_nxt  = w_sel;
        end
      end
      ST_XFER: begin
        if (w_accept) begin
          if (r_beat_cnt != '1) begin
            w_beat_cnt_nxt = r_beat_cnt + CW'(1);
          end
          if (w_release) begin
            w_state_nxt    = ST_IDLE;
            w_beat_cnt_nxt = '0;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Arbiter state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_grant     <= '0;
      r_last_port <= LAST_RST;
      r_beat_cnt  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_grant     <= w_grant_nxt;
      r_last_port <= w_last_nxt;
      r_beat_cnt  <= w_beat_cnt_nxt;
    end
  end

  // Output register: load on accept, drop valid once consumed with nothing new
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m_tdata  <= '0;
      r_m_tvalid <= 1'b0;
      r_m_tlast  <= 1'b0;
      r_m_tid    <= '0;
    end else if (w_accept) begin
      r_m_tdata  <= w_sdata[r_grant];
      r_m_tvalid <= 1'b1;
      r_m_tlast  <= w_release;
      r_m_tid    <= ID_BITS'(r_grant);
    end else if (m_axis_tready) begin
      r_m_tvalid <= 1'b0;
    end
  end

  assign s_axis_tready = w_ready;
  assign m_axis_tdata  = r_m_tdata;
  assign m_axis_tvalid = r_m_tvalid;
  assign m_axis_tlast  = r_m_tlast;
  assign m_axis_tid    = r_m_tid;

endmodule
